cla_pipe_adder: RTL and testbench

CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

---
 rtl/cla_pkg.sv | 24 ++
 rtl/cla_pipe_adder_if.sv | 28 ++
 rtl/cla_nibble_slice.sv | 29 ++
 rtl/cla_pipe_adder.sv | 92 +++++++++
 tb/tb_cla_pipe_adder.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants, stage record and width check for the pipelined CLA adder.
package cla_pkg;

    localparam int NIBBLE    = 4;
    localparam int MAX_WIDTH = 64;

    // Operand and sum fields are sized for the widest legal adder; narrower builds leave the top bits zero.
    typedef struct packed {
        logic                 valid;
        logic                 sub;
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
        logic [MAX_WIDTH-1:0] sum;
        logic                 carry;
        logic                 pg;
        logic                 gg;
        logic                 ovf;
    } stage_t;

    function automatic bit width_ok(input int w);
        return (w % NIBBLE == 0) && (w >= 2 * NIBBLE) && (w <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// rtl/cla_pipe_adder_if.sv - operand/result handshake bundle of the pipelined CLA adder.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             pg;
    logic             gg;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, pg, gg
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, pg, gg
    );
endinterface

// File: rtl/cla_nibble_slice.sv
// rtl/cla_nibble_slice.sv - combinational 4-bit carry-lookahead block.
module cla_nibble_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c,
    output logic [3:0] s,
    output logic       p_group,
    output logic       g_group,
    output logic       c_out
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    assign w_c[0] = c;
    assign w_c[1] = w_g[0] | (w_p[0] & c);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & c);

    assign s       = w_p ^ w_c;
    assign p_group = &w_p;
    assign g_group = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign c_out   = g_group | (p_group & c);
endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead adder/subtractor, one nibble resolved per stage.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    cla_pipe_adder_if.slave   bus
);
    localparam int BLOCKS = WIDTH / NIBBLE;

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a multiple of 4 between 8 and %0d", MAX_WIDTH);
    end

    stage_t [BLOCKS-1:0] r_stage;
    stage_t [BLOCKS-1:0] w_nxt;
    stage_t              w_in;
    logic                w_stall;
    logic                w_unused;

    // Subtraction is folded in before stage 0: b is inverted and the carry-in forced high.
    always_comb begin
        w_in              = '0;
        w_in.valid        = bus.in_valid;
        w_in.sub          = bus.sub;
        w_in.a[WIDTH-1:0] = bus.a;
        w_in.b[WIDTH-1:0] = bus.sub ? ~bus.b : bus.b;
        w_in.carry        = bus.sub | bus.cin;
        w_in.pg           = 1'b1;
    end

    for (genvar k = 0; k < BLOCKS; k++) begin : g_stage
        stage_t            w_src;
        stage_t            w_res;
        logic [NIBBLE-1:0] w_s;
        logic              w_p;
        logic              w_g;
        logic              w_co;

        if (k == 0) begin : g_head
            assign w_src = w_in;
        end else begin : g_tail
            assign w_src = r_stage[k-1];
        end

        cla_nibble_slice u_slice (
            .a       (w_src.a[NIBBLE*k +: NIBBLE]),
            .b       (w_src.b[NIBBLE*k +: NIBBLE]),
            .c       (w_src.carry),
            .s       (w_s),
            .p_group (w_p),
            .g_group (w_g),
            .c_out   (w_co)
        );

        // ovf is refreshed every stage; only the value computed on the top nibble survives.
        always_comb begin
            w_res                          = w_src;
            w_res.sum[NIBBLE*k +: NIBBLE]  = w_s;
            w_res.carry                    = w_co;
            w_res.pg                       = w_src.pg & w_p;
            w_res.gg                       = w_g | (w_p & w_src.gg);
            w_res.ovf                      = w_co ^ w_s[NIBBLE-1]
                                           ^ w_src.a[NIBBLE*k+NIBBLE-1]
                                           ^ w_src.b[NIBBLE*k+NIBBLE-1];
        end

        assign w_nxt[k] = w_res;
    end

    assign w_stall = r_stage[BLOCKS-1].valid & ~bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
        end else if (!w_stall) begin
            r_stage <= w_nxt;
        end
    end

    assign bus.in_ready  = ~w_stall;
    assign bus.out_valid = r_stage[BLOCKS-1].valid;
    assign bus.sum       = r_stage[BLOCKS-1].sum[WIDTH-1:0];
    assign bus.cout      = r_stage[BLOCKS-1].carry;
    assign bus.ovf       = r_stage[BLOCKS-1].ovf;
    assign bus.pg        = r_stage[BLOCKS-1].pg;
    assign bus.gg        = r_stage[BLOCKS-1].gg;

    assign w_unused = ^r_stage[BLOCKS-1];
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - directed-vector self-checking bench for cla_pipe_adder (WIDTH=16).
module tb_cla_pipe_adder;
    localparam int WIDTH = 16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    cla_pipe_adder_if #(.WIDTH(WIDTH)) bus ();

    cla_pipe_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic sub, input logic [15:0] e_sum,
                           input logic e_cout, input logic e_ovf, input logic e_pg, input logic e_gg);
        int lat;
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_eq({tag, ".latency"}, lat, 4);
        check_eq({tag, ".sum"},  bus.sum,  e_sum);
        check_eq({tag, ".cout"}, bus.cout, e_cout);
        check_eq({tag, ".ovf"},  bus.ovf,  e_ovf);
        check_eq({tag, ".pg"},   bus.pg,   e_pg);
        check_eq({tag, ".gg"},   bus.gg,   e_gg);
        tick();
        check_eq({tag, ".drain"}, bus.out_valid, 1'b0);
    endtask

    logic [15:0] exp_sum  [4];
    logic        exp_cout [4];
    int          seen;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check_eq("rst.out_valid", bus.out_valid, 1'b0);
        check_eq("rst.in_ready",  bus.in_ready,  1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        check_eq("rst.sum",  bus.sum,  16'h0000);
        check_eq("rst.flags", {bus.cout, bus.ovf, bus.pg, bus.gg}, 4'b0000);

        run_one("v_inc",   16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        run_one("v_wrap",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        run_one("v_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
        run_one("v_sub",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        run_one("v_prop",  16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        run_one("v_gen",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);

        // Back-to-back inputs, then a 5-cycle downstream stall with a fourth input waiting.
        bus.cin = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
        bus.a = 16'h1111; bus.b = 16'h2222; tick();
        bus.a = 16'h00FF; bus.b = 16'h0001; tick();
        bus.a = 16'hF000; bus.b = 16'h1000; tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        bus.a = 16'h0010; bus.b = 16'h0020; bus.in_valid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("stall%0d.in_ready", i), bus.in_ready, 1'b0);
            check_eq($sformatf("stall%0d.out_valid", i), bus.out_valid, 1'b1);
            check_eq($sformatf("stall%0d.sum", i), bus.sum, 16'h3333);
            if (i < 4) tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check_eq("release.in_ready", bus.in_ready, 1'b1);
        exp_sum[0] = 16'h3333; exp_cout[0] = 1'b0;
        exp_sum[1] = 16'h0100; exp_cout[1] = 1'b0;
        exp_sum[2] = 16'h0000; exp_cout[2] = 1'b1;
        exp_sum[3] = 16'h0030; exp_cout[3] = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.out_valid) begin
                if (seen < 4) begin
                    check_eq($sformatf("order%0d.sum", seen), bus.sum, exp_sum[seen]);
                    check_eq($sformatf("order%0d.cout", seen), bus.cout, exp_cout[seen]);
                end
                seen++;
            end
            tick();
            bus.in_valid = 1'b0;
        end
        check_eq("order.count", seen, 4);

        // Reset with three transactions in flight.
        bus.in_valid = 1'b1;
        bus.a = 16'h0101; bus.b = 16'h0101; tick();
        bus.a = 16'h0202; bus.b = 16'h0202; tick();
        bus.a = 16'h0303; bus.b = 16'h0303; tick();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("midrst.out_valid", bus.out_valid, 1'b0);
        check_eq("midrst.in_ready",  bus.in_ready,  1'b1);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.out_valid) seen++;
            tick();
        end
        check_eq("midrst.ghosts", seen, 0);
        run_one("v_after", 16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
